// File: rtl/p2s_if.sv
// Bundles the p2s framer's control, stack and line signals.
// The master side drives the frame request and the stack data; the slave side is the framer.
interface p2s_if;
  logic        start;
  logic [15:0] frameLen;
  logic [7:0]  codeWord;
  logic        wordValid;
  logic        hold;
  logic        wordRead;
  logic        serOut;
  logic        busy;
  logic        done;
  logic        underrun;

  modport master (
    output start, frameLen, codeWord, wordValid, hold,
    input  wordRead, serOut, busy, done, underrun
  );

  modport slave (
    input  start, frameLen, codeWord, wordValid, hold,
    output wordRead, serOut, busy, done, underrun
  );
endinterface

// File: rtl/p2s.sv
// Parallel-to-serial framer: begin flag, 16-bit length header, payload bytes and end flag,
// one bit per tclk, MSB first.
//
// state  | meaning
// IDLE   | line at 0, waiting for start
// FLAG_B | shifting the begin flag
// HDR    | shifting the 16-bit length, high byte first
// DATA   | shifting payload bytes
// FLAG_E | shifting the end flag, done pulses on exit
module p2s #(
  parameter logic [7:0] FLAG = 8'h1B
) (
  input  logic tclk,
  input  logic rst,
  p2s_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLAG_B = 3'd1,
    HDR    = 3'd2,
    DATA   = 3'd3,
    FLAG_E = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        ser_q, ser_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] len_q, len_d;
  logic        underrun_q, underrun_d;
  logic        done_q, done_d;

  logic        word_read;
  logic        last_bit;
  logic        load_en;
  logic        shift_en;
  logic        fetch;
  logic [7:0]  load_byte;

  always_ff @(posedge tclk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= 8'h00;
      ser_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      ser_q      <= ser_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    ser_d      = ser_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    word_read  = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    fetch      = 1'b0;
    load_byte  = 8'h00;
    last_bit   = (bit_cnt_q == 3'd7);

    unique case (state_q)
      IDLE: begin
        // hold in the same cycle as start drops the request entirely
        if (bus.start && !bus.hold) begin
          len_d      = bus.frameLen;
          underrun_d = 1'b0;
          byte_cnt_d = 16'd0;
          load_byte  = FLAG;
          load_en    = 1'b1;
          state_d    = FLAG_B;
        end
      end
      FLAG_B: begin
        if (!bus.hold) begin
          if (last_bit) begin
            load_byte  = len_q[15:8];
            load_en    = 1'b1;
            byte_cnt_d = 16'd0;
            state_d    = HDR;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      HDR: begin
        if (!bus.hold) begin
          if (last_bit) begin
            load_en = 1'b1;
            if (byte_cnt_q == 16'd0) begin
              load_byte  = len_q[7:0];
              byte_cnt_d = 16'd1;
            end else if (len_q != 16'd0) begin
              fetch      = 1'b1;
              byte_cnt_d = 16'd0;
              state_d    = DATA;
            end else begin
              load_byte  = FLAG;
              byte_cnt_d = 16'd0;
              state_d    = FLAG_E;
            end
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (!bus.hold) begin
          if (last_bit) begin
            load_en = 1'b1;
            if (byte_cnt_q == len_q - 16'd1) begin
              load_byte  = FLAG;
              byte_cnt_d = 16'd0;
              state_d    = FLAG_E;
            end else begin
              fetch      = 1'b1;
              byte_cnt_d = byte_cnt_q + 16'd1;
            end
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      FLAG_E: begin
        if (!bus.hold) begin
          if (last_bit) begin
            ser_d     = 1'b0;
            shreg_d   = 8'h00;
            bit_cnt_d = 3'd0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // an empty stack still advances the byte count so the frame length on the line is preserved
    if (fetch) begin
      if (bus.wordValid) begin
        word_read = 1'b1;
        load_byte = bus.codeWord;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (load_en) begin
      ser_d     = load_byte[7];
      shreg_d   = {load_byte[6:0], 1'b0};
      bit_cnt_d = 3'd0;
    end else if (shift_en) begin
      ser_d     = shreg_q[7];
      shreg_d   = {shreg_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  assign bus.serOut   = ser_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.wordRead = word_read;
  assign bus.underrun = underrun_q;

endmodule

// File: doc/p2s.md
# p2s

Parallel-to-serial framer: the transmit end of the serial codeword link. Pops 8-bit codewords from an upstream stack/FIFO and emits a one-bit-per-`tclk` frame: a begin flag, a 16-bit length header, the payload bytes, and an end flag. The frame is what the `s2p` receiver consumes: it detects the flag, skips the 16 header bits, then collects bytes. Sits between the RLE encoder's output stack and the serial line.

## Interface
Parameters:
- `FLAG`, 8'h1B: begin/end flag byte, sent MSB first.

Ports:
- `tclk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `frameLen`  in  16  payload byte count; captured on accepted `start`.
- `codeWord`  in  8  next payload byte from the stack; must be valid while `wordValid` is high.
- `wordValid`  in  1  stack non-empty.
- `hold`  in  1  freeze the transmitter; no state advance.
- `wordRead`  out  1  pop strobe; `codeWord` is consumed at the rising edge ending this cycle.
- `serOut`  out  1  serial data, registered.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `underrun`  out  1  sticky: a payload byte was due while `wordValid` was low.

## Operation
- Reset: state IDLE, all counters 0, and `serOut`, `busy`, `done`, `wordRead` and `underrun` all at 0. Reset takes effect mid-frame with no end flag sent. The line idles at 0.
- State machine, 8-bit shift register, 3-bit bit counter, 16-bit byte counter:
  - IDLE: `start` = 1 → load `FLAG`, latch `frameLen`, clear `underrun`, go FLAG_B.
  - FLAG_B: 8 bits → HDR.
  - HDR: 16 bits of latched `frameLen`, MSB first → DATA if length ≠ 0, otherwise → FLAG_E.
  - DATA: 8 bits per byte. After the last bit of byte `frameLen`-1 → FLAG_E.
  - FLAG_E: 8 bits of `FLAG` → IDLE, with `done` pulsed.
- `start` is ignored when not in IDLE. `start` and `hold` in the same IDLE cycle: `hold` wins, and the request is not latched.
- Byte loading: on the edge ending the last bit of HDR, or of any non-final DATA byte, the shifter loads the next payload byte.
  - If `wordValid` = 1: `wordRead` is high that cycle and `codeWord` is loaded.
  - If `wordValid` = 0: `wordRead` stays low, 8'h00 is loaded, `underrun` is set, and byte count still advances. Frame length on the line is never altered.
- `hold` = 1: state, counters, shifter and `serOut` frozen. `wordRead` is forced low and the pending load is deferred until `hold` drops. `done` is deferred likewise.
- Payload bytes equal to `FLAG`, and flag patterns across byte boundaries, are not escaped. The upstream encoder guarantees none occur.
- `frameLen` is 16 bits unsigned. 65535 is the maximum, and the byte counter does not wrap inside a frame.

## Timing
- `start` sampled at edge E0 → first flag bit (0) on `serOut` in the cycle after E0. `busy` rises in the same cycle.
- With no `hold`, bit k of the frame (k = 0..) is driven in cycle E0+1+k.
- Frame length is 32 + 8·L cycles. `busy` is high for exactly those cycles.
- `done` is high in cycle E0+33+8·L, with `busy` = 0 and `serOut` = 0. A new `start` is accepted in that same cycle.
- `wordRead` for payload byte i (i = 0..L-1) is high in cycle E0+24+8·i, which is the last bit of the previous field. At most one `wordRead` per 8 cycles.
- Each `hold` cycle shifts all later events by one cycle.

## Test plan
- Reset: assert `rst` mid-frame with `serOut` = 1 → next cycle `serOut`/`busy`/`done`/`wordRead`/`underrun` = 0, state IDLE, and a subsequent `start` produces a clean frame.
- L=1, codeWord 8'hA5, `wordValid` held 1:
  - `serOut` cycles 1..40 = 00011011, 0000000000000001, 10100101, 00011011.
  - `wordRead` in cycle 24 only.
  - `done` in cycle 41.
- L=0: 32 bits (flag, 16 zeros, flag), no `wordRead`, `done` in cycle 33.
- Underrun, L=2 with `wordValid` low at cycle 32: byte 1 sent as 8'h00, `underrun` goes 1 and stays 1 after `done`, and clears on the next accepted `start`.
- Hold, L=1: `hold` high for cycles 10..12 → `serOut` frozen at its cycle-9 value, and all later bits, `wordRead` (cycle 27) and `done` (cycle 44) delayed by 3.
- Loopback into `s2p` with `stackFull` = 0, L=4, bytes 12, 34, 56, 78 → receiver `codeWord` presents 12, 34, 56, 78 in order with one `valid` per byte. No `valid` after the end flag is detected.
